// File: rtl/galois8_pkg.sv
// Shared GF(2^8) types and constants for the pipelined multiplier.
package galois8_pkg;
    typedef logic [7:0]  gf8_t;
    typedef logic [14:0] gf8_prod_t;

    localparam logic [8:0] GF8_POLY        = 9'h1C3;
    localparam int         GF8_MUL_LATENCY = 9;
endpackage

// File: rtl/galois8_reduce.sv
// Combinational reduction of a 15-bit carry-less product modulo x^8+x^7+x^6+x+1.
module galois8_reduce
    import galois8_pkg::*;
(
    input  logic [14:0] prod,
    output logic [7:0]  res
);
    always_comb begin
        gf8_prod_t r;
        r = prod;
        // Clear bits from the top down; each fold can only touch lower bits.
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (gf8_prod_t'(GF8_POLY) << (i - 8));
        end
        res = r[7:0];
    end
endmodule

// File: rtl/galois8_mul.sv
// 9-stage pipelined GF(2^8) multiplier (poly 0x1C3), one result per clock.
// Define GALOIS8_MUL_VALID_EN to add an in_valid/out_valid sideband.
module galois8_mul
    import galois8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
`ifdef GALOIS8_MUL_VALID_EN
    input  logic       in_valid,
    output logic       out_valid,
`endif
    input  logic [7:0] left,
    input  logic [7:0] right,
    output logic [7:0] result
);
    gf8_prod_t [7:0] pp_c;
    gf8_prod_t       acc_fin;
    gf8_t            red_c;

    always_comb begin
        for (int i = 0; i < 8; i++)
            pp_c[i] = left[i] ? (gf8_prod_t'(right) << i) : '0;
    end

    // Stage j holds the running sum and the partial products not yet folded in;
    // the remainder list shrinks by one entry per stage.
    for (genvar j = 0; j < 7; j++) begin : g_acc
        gf8_prod_t         acc;
        gf8_prod_t [6-j:0] rem;

        if (j == 0) begin : g_cap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                    rem <= '0;
                end else begin
                    acc <= pp_c[0];
                    rem <= pp_c[7:1];
                end
            end
        end else begin : g_xor
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                    rem <= '0;
                end else begin
                    acc <= g_acc[j-1].acc ^ g_acc[j-1].rem[0];
                    rem <= g_acc[j-1].rem[7-j:1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_fin <= '0;
        else        acc_fin <= g_acc[6].acc ^ g_acc[6].rem[0];
    end

    galois8_reduce u_reduce (
        .prod (acc_fin),
        .res  (red_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result <= '0;
        else        result <= red_c;
    end

`ifdef GALOIS8_MUL_VALID_EN
    logic [GF8_MUL_LATENCY-1:0] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[GF8_MUL_LATENCY-2:0], in_valid};
    end

    assign out_valid = vld_pipe[GF8_MUL_LATENCY-1];
`endif
endmodule

// File: tb/tb_galois8_mul.sv
// Scoreboard bench for galois8_mul: driver queues expected results, monitor checks each cycle.
module tb_galois8_mul;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] left = '0;
    logic [7:0] right = '0;
    logic [7:0] result;
`ifdef GALOIS8_MUL_VALID_EN
    logic       in_valid = 1'b0;
    logic       out_valid;
`endif

    typedef struct {
        logic [7:0] res;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   pend_release = 1'b0;

    galois8_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef GALOIS8_MUL_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .left      (left),
        .right     (right),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Shift-and-add multiply with xtime reduction: x*a, folding 0x1C3 on overflow.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        int y = b;
        for (int i = 0; i < 8; i++) begin
            if (y % 2 == 1) p = p ^ x;
            x = x * 2;
            if (x >= 256) x = x ^ 'h1C3;
            y = y / 2;
        end
        return 8'(p);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    // Issue one operand pair on the falling edge and queue its expected response.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e, input bit v);
        exp_t x;
        @(negedge clk);
        if (pend_release) begin
            rst_n = 1'b1;
            x.res = 8'h00;
            x.vld = 1'b0;
            repeat (8) exp_q.push_back(x);
            mon_en = 1'b1;
            pend_release = 1'b0;
        end
        left  = a;
        right = b;
`ifdef GALOIS8_MUL_VALID_EN
        in_valid = v;
`endif
        x.res = e;
        x.vld = v;
        exp_q.push_back(x);
    endtask

    task automatic drive_rand(input int n);
        logic [7:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            drive(a, b, gf_mul(a, b), 1'($urandom));
            if (i % 5 == 0) drive(b, a, gf_mul(a, b), 1'b1);
        end
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        mon_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check({name, "_result"}, result, 8'h00);
`ifdef GALOIS8_MUL_VALID_EN
        check({name, "_out_valid"}, 8'(out_valid), 8'h00);
`endif
        exp_q.delete();
        pend_release = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL underflow: output with no expected entry, result=%02h", result);
            end else begin
                e = exp_q.pop_front();
                check("stream_result", result, e.res);
`ifdef GALOIS8_MUL_VALID_EN
                check("stream_out_valid", 8'(out_valid), 8'(e.vld));
`endif
            end
        end
    end

    initial begin
        #1;
        check("reset_result", result, 8'h00);
`ifdef GALOIS8_MUL_VALID_EN
        check("reset_out_valid", 8'(out_valid), 8'h00);
`endif
        pend_release = 1'b1;

        drive(8'h72, 8'h69, 8'h8C, 1'b1);
        drive(8'h69, 8'h72, 8'h8C, 1'b0);
        drive(8'h02, 8'h80, 8'hC3, 1'b1);
        drive(8'h80, 8'h80, 8'h77, 1'b1);
        drive(8'h00, 8'hFF, 8'h00, 1'b0);
        drive(8'hFF, 8'h00, 8'h00, 1'b1);
        drive(8'h01, 8'h5A, 8'h5A, 1'b0);
        drive(8'h5A, 8'h01, 8'h5A, 1'b1);
        drive_rand(40);

        async_reset("midstream_reset");
        drive(8'hA7, 8'h3C, gf_mul(8'hA7, 8'h3C), 1'b1);
        drive(8'h11, 8'h22, gf_mul(8'h11, 8'h22), 1'b0);
        drive(8'hFE, 8'hFD, gf_mul(8'hFE, 8'hFD), 1'b1);
        drive(8'h80, 8'h03, gf_mul(8'h80, 8'h03), 1'b1);
        drive_rand(30);

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/galois8_mul.md
GALOIS8_MUL -- requirements
Module: galois8_mul

Interface
REQ-001 The module SHALL have no parameters; the field polynomial and latency are fixed constants.
REQ-002 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and be the asynchronous, active-low reset.
REQ-004 Port left SHALL be an input, 8 bits wide, carrying GF(2^8) operand A.
REQ-005 Port right SHALL be an input, 8 bits wide, carrying GF(2^8) operand B.
REQ-006 Port result SHALL be an output, 8 bits wide, carrying the registered product A*B in GF(2^8).

Function
REQ-007 The product SHALL be computed in GF(2^8) with reduction polynomial x^8+x^7+x^6+x+1 (0x1C3).
REQ-008 Addition SHALL be bitwise XOR; the unreduced carry-less product SHALL be 15 bits wide; reduction SHALL yield exactly 8 bits.
REQ-009 The datapath SHALL be a 9-register-stage pipeline:
- stage 1: capture operands and form the 8 AND-masked, shifted partial products;
- stages 2-8: XOR-accumulate the partial products, one XOR level per stage;
- stage 9: reduce mod 0x1C3 and register result.
REQ-010 Operands present before rising edge k SHALL appear on result immediately after rising edge k+8; latency SHALL be 9 clocks.
REQ-011 The pipeline SHALL be fully pipelined: it SHALL accept a new operand pair every cycle and emit one result per cycle, in order.
REQ-012 The block SHALL have no stall, enable or handshake in the base build; data SHALL flow every cycle.
REQ-013 Boundary behaviour: an operand of 0x00 SHALL yield 0x00, an operand of 0x01 SHALL yield the other operand, and the operation SHALL be commutative.

Reset
REQ-014 Asserting rst_n low SHALL asynchronously clear every pipeline register, so result reads 0x00 without waiting for a clock edge.
REQ-015 Reset mid-operation SHALL discard all in-flight operands; after deassertion, the first meaningful result SHALL appear 9 rising edges after the first sampled operands.
REQ-016 Between reset release and that first meaningful result, result SHALL output 0x00.

Configuration
REQ-017 When macro GALOIS8_MUL_VALID_EN is defined, the block SHALL add two ports: input in_valid (1 bit) and output out_valid (1 bit).
REQ-018 With GALOIS8_MUL_VALID_EN defined, out_valid SHALL be in_valid delayed by exactly 9 clocks through a 9-bit shift register cleared by rst_n.
REQ-019 With GALOIS8_MUL_VALID_EN defined, the data path and result SHALL be identical to the base build, independent of in_valid.
REQ-020 When GALOIS8_MUL_VALID_EN is not defined, in_valid, out_valid and the valid shift register SHALL be absent.

Structure
REQ-021 A shared package galois8_pkg SHALL hold:
- the gf8_t typedef (8-bit);
- the unreduced-product typedef (15-bit);
- the constant GF8_POLY = 9'h1C3;
- the constant GF8_MUL_LATENCY = 9.
REQ-022 One sub-module, galois8_reduce, SHALL implement the purely combinational 15-to-8-bit reduction mod 0x1C3 used in stage 9; everything else SHALL be in galois8_mul.

Verification
REQ-023 Apply left=0x72 and right=0x69 for one cycle -> result=0x8C exactly 9 clocks later; swapping to left=0x69, right=0x72 SHALL also give 0x8C.
REQ-024 Apply 0x02*0x80 -> 0xC3, and 0x80*0x80 -> 0x77 (reduction path exercised).
REQ-025 Apply 0x00*0xFF -> 0x00, and 0x01*0x5A -> 0x5A (identity and zero operands).
REQ-026 Stream a back-to-back sequence with new operands every cycle -> each result matches a golden model in order, with latency 9 and no bubbles.
REQ-027 Drop rst_n low asynchronously mid-stream -> result reads 0x00 immediately; after release, outputs are 0x00 until the first post-reset operands emerge 9 clocks later.
REQ-028 With GALOIS8_MUL_VALID_EN defined, pulse in_valid in a 1,0,1,1 pattern -> out_valid reproduces the same pattern 9 clocks later, and out_valid is cleared by reset.
